// File: rtl/alu_pkg.sv
// Shared ALU sequencer definitions: opcode encodings, FSM state type and request layout.
// Optional response error flag is enabled with ALU_SEQ_ERR_EN (see alu_sequencer).
package alu_pkg;

  localparam logic [3:0] SOP_ADD  = 4'b0000;
  localparam logic [3:0] SOP_SUB  = 4'b0001;
  localparam logic [3:0] SOP_MULT = 4'b0010;
  localparam logic [3:0] SOP_DIV  = 4'b0011;
  localparam logic [3:0] SOP_AND  = 4'b0100;
  localparam logic [3:0] SOP_OR   = 4'b0101;
  localparam logic [3:0] SOP_XOR  = 4'b0110;
  localparam logic [3:0] SOP_NOP  = 4'b0111;
  localparam logic [3:0] SOP_SLL  = 4'b1000;
  localparam logic [3:0] SOP_SRL  = 4'b1001;
  localparam logic [3:0] SOP_SRA  = 4'b1010;
  localparam logic [3:0] SOP_SLT  = 4'b1011;
  localparam logic [3:0] SOP_SW   = 4'b1100;
  localparam logic [3:0] SOP_LW   = 4'b1101;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_EXEC = 2'd1;
  localparam state_t S_RESP = 2'd2;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  sop;
  } alu_req_t;

  // 4'b1110 and 4'b1111 are the only unassigned encodings.
  function automatic logic sop_illegal(input logic [3:0] sop);
    return sop[3:1] == 3'b111;
  endfunction

  function automatic int unsigned op_latency(input logic [3:0] sop,
                                             input int unsigned base_cyc,
                                             input int unsigned mult_cyc,
                                             input int unsigned div_cyc);
    int unsigned lat;
    case (sop)
      SOP_MULT: lat = mult_cyc;
      SOP_DIV:  lat = div_cyc;
      default:  lat = base_cyc;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; pointer remembers the last winner and moves on each grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       gid
);

  logic last_q, last_d;

  always_comb begin
    gid = valid[1];
    if (valid == 2'b11) gid = ~last_q;
    grant  = 2'b00;
    if (enable && (valid != 2'b00)) grant[gid] = 1'b1;
    last_d = last_q;
    if (grant != 2'b00) last_d = gid;
  end

  // Reset as if requester 1 won last, so requester 0 is favoured first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Shares one external combinational ALU between two requesters: arbitrate, register
// operands, wait an opcode-dependent latency, then hand back the result. ALU_SEQ_ERR_EN adds rsp_err.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned BASE_CYC = 1,
  parameter int unsigned MULT_CYC = 3,
  parameter int unsigned DIV_CYC  = 6,
  parameter int unsigned CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic [3:0]  req0_sop,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  input  logic [3:0]  req1_sop,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [3:0]  alu_sop,
  input  logic [31:0] alu_rop,
  input  logic        alu_zf,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_zf,
`ifdef ALU_SEQ_ERR_EN
  output logic        rsp_err,
`endif
  output logic        busy
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      op1_q, op1_d, op2_q, op2_d;
  logic [3:0]       sop_q, sop_d;
  logic             id_q, id_d;
  logic             vld_q, vld_d;
  logic [31:0]      data_q, data_d;
  logic             zf_q, zf_d;

  logic [1:0]       grant;
  logic             gid;
  logic             accept;
  logic             divz;
  alu_req_t         req_sel;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state_q == S_IDLE),
    .valid  ({req1_valid, req0_valid}),
    .grant  (grant),
    .gid    (gid)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;

  always_comb begin
    req_sel = '{op1: req0_op1, op2: req0_op2, sop: req0_sop};
    if (gid) req_sel = '{op1: req1_op1, op2: req1_op2, sop: req1_sop};
  end

  // The ALU's divide-by-zero output is meaningless; a saturated result is reported instead.
  assign divz = (sop_q == SOP_DIV) && (op2_q == 32'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    sop_d   = sop_q;
    id_d    = id_q;
    vld_d   = vld_q;
    data_d  = data_q;
    zf_d    = zf_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op1_d = req_sel.op1;
          op2_d = req_sel.op2;
          sop_d = req_sel.sop;
          id_d  = gid;
          cnt_d = CNT_W'(op_latency(req_sel.sop, BASE_CYC, MULT_CYC, DIV_CYC) - 1);
          if (sop_illegal(req_sel.sop)) begin
            data_d  = 32'd0;
            zf_d    = 1'b1;
            vld_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          data_d  = divz ? 32'hFFFF_FFFF : alu_rop;
          zf_d    = divz ? 1'b0 : alu_zf;
          vld_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          vld_d   = 1'b0;
          sop_d   = SOP_NOP;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op1_q   <= 32'd0;
      op2_q   <= 32'd0;
      sop_q   <= SOP_NOP;
      id_q    <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= 32'd0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sop_q   <= sop_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      zf_q    <= zf_d;
    end
  end

`ifdef ALU_SEQ_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                err_q <= 1'b0;
    else if ((state_q == S_IDLE) && accept)    err_q <= sop_illegal(req_sel.sop);
    else if ((state_q == S_EXEC) && cnt_q == '0) err_q <= divz;
  end
  assign rsp_err = err_q;
`endif

  assign alu_op1   = op1_q;
  assign alu_op2   = op2_q;
  assign alu_sop   = sop_q;
  assign rsp_valid = vld_q;
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_zf    = zf_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with a behavioural ALU and reference model.
`timescale 1ns/1ps
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] r_op1 [2];
  logic [31:0] r_op2 [2];
  logic [3:0]  r_sop [2];
  logic [31:0] alu_op1, alu_op2, alu_rop;
  logic [3:0]  alu_sop;
  logic        alu_zf;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zf, busy;
  logic [31:0] rsp_data;
`ifdef ALU_SEQ_ERR_EN
  logic        rsp_err;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int last_g = 1;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op1(r_op1[0]), .req0_op2(r_op2[0]), .req0_sop(r_sop[0]),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op1(r_op1[1]), .req1_op2(r_op2[1]), .req1_sop(r_sop[1]),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sop(alu_sop),
    .alu_rop(alu_rop), .alu_zf(alu_zf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zf(rsp_zf),
`ifdef ALU_SEQ_ERR_EN
    .rsp_err(rsp_err),
`endif
    .busy(busy)
  );

  // Behavioural ALU: divide-by-zero and unassigned opcodes give junk that must never reach rsp_data.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] s);
    case (s)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a * b;
      4'd3:  return (b == 0) ? 32'hDEAD_BEEF : a / b;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return a ^ b;
      4'd8:  return a << b[4:0];
      4'd9:  return a >> b[4:0];
      4'd10: return 32'($signed(a) >>> b[4:0]);
      4'd11: return {31'd0, $signed(a) < $signed(b)};
      4'd12, 4'd13: return a + b;
      default: return 32'hA5A5_A5A5;
    endcase
  endfunction

  assign alu_rop = alu_fn(alu_op1, alu_op2, alu_sop);
  assign alu_zf  = (alu_rop == 32'd0);

  function automatic int exp_lat(input logic [3:0] s);
    if (s == 4'hE || s == 4'hF) return 0;
    if (s == 4'd2) return 3;
    if (s == 4'd3) return 6;
    return 1;
  endfunction

  // {err, zf, data}
  function automatic logic [33:0] exp_rsp(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] s);
    logic [31:0] d;
    if (s == 4'hE || s == 4'hF) return {1'b1, 1'b1, 32'd0};
    if (s == 4'd3 && b == 0)    return {1'b1, 1'b0, 32'hFFFF_FFFF};
    d = alu_fn(a, b, s);
    return {1'b0, d == 32'd0, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] s);
    r_op1[r] = a; r_op2[r] = b; r_sop[r] = s;
    if (r == 0) req0_valid = 1'b1;
    else        req1_valid = 1'b1;
  endtask

  // Waits for a grant, follows the op to its response, optionally stalls, then completes it.
  task automatic issue(input int stall, input bit keep);
    int n, g, ewin, el;
    logic [31:0] a, b;
    logic [3:0]  s;
    logic [33:0] e;
    n = 0;
    do begin @(negedge clk); n++; end while (!(req0_ready || req1_ready) && n < 50);
    check("grant_seen", 32'(req0_ready | req1_ready), 32'd1);
    check("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
    g    = req1_ready ? 1 : 0;
    ewin = (req0_valid && req1_valid) ? 1 - last_g : (req1_valid ? 1 : 0);
    check("winner", 32'(g), 32'(ewin));
    a = r_op1[g]; b = r_op2[g]; s = r_sop[g];
    el = exp_lat(s);
    e  = exp_rsp(a, b, s);
    @(posedge clk); #1;
    last_g = g;
    if (!keep) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    check("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("latency", 32'(n), 32'(el));
    check("rsp_id", 32'(rsp_id), 32'(g));
    check("rsp_data", rsp_data, e[31:0]);
    check("rsp_zf", 32'(rsp_zf), 32'(e[32]));
`ifdef ALU_SEQ_ERR_EN
    check("rsp_err", 32'(rsp_err), 32'(e[33]));
`endif
    check("alu_op1_held", alu_op1, a);
    check("alu_op2_held", alu_op2, b);
    check("alu_sop_held", 32'(alu_sop), 32'(s));
    repeat (stall) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data", rsp_data, e[31:0]);
      check("stall_noready", 32'(req0_ready | req1_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("hs_valid", 32'(rsp_valid), 32'd0);
    check("hs_busy", 32'(busy), 32'd0);
    check("hs_nop", 32'(alu_sop), 32'h7);
    if (req0_valid || req1_valid)
      check("next_ready", 32'(req0_ready | req1_ready), 32'd1);
  endtask

  task automatic check_reset_vals();
    check("rst_op1", alu_op1, 32'd0);
    check("rst_op2", alu_op2, 32'd0);
    check("rst_sop", 32'(alu_sop), 32'h7);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_data", rsp_data, 32'd0);
    check("rst_zf", 32'(rsp_zf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
    last_g = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin r_op1[i] = 0; r_op2[i] = 0; r_sop[i] = 0; end
    do_reset();

    set_req(0, 32'd5, 32'd7, 4'd0);     issue(0, 1'b0);
    set_req(1, 32'd6, 32'd7, 4'd2);     issue(0, 1'b0);
    set_req(0, 32'd100, 32'd0, 4'd3);   issue(0, 1'b0);
    set_req(0, 32'd100, 32'd7, 4'd3);   issue(0, 1'b0);
    set_req(1, 32'd3, 32'd4, 4'hE);     issue(0, 1'b0);
    set_req(0, 32'd3, 32'd3, 4'hF);     issue(1, 1'b0);

    // Backpressure with the other requester waiting.
    set_req(0, 32'd11, 32'd22, 4'd0);
    set_req(1, 32'd1, 32'd1, 4'd1);
    issue(5, 1'b1);
    issue(0, 1'b0);

    // Contention from a fresh pointer: grants must alternate 0,1,0,1.
    do_reset();
    set_req(0, 32'd9, 32'd9, 4'd1);
    set_req(1, 32'd9, 32'd9, 4'd1);
    for (int k = 0; k < 4; k++) begin
      issue(0, 1'b1);
      check("contention_order", 32'(last_g), 32'(k % 2));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;

    // Reset during DIV EXEC aborts the op.
    set_req(0, 32'd100, 32'd7, 4'd3);
    n = 0;
    do begin @(negedge clk); n++; end while (!req0_ready && n < 50);
    check("rst_test_grant", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    last_g = 1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
    end
    set_req(0, 32'd1, 32'd2, 4'd0);
    set_req(1, 32'd3, 32'd4, 4'd0);
    issue(0, 1'b0);
    check("first_grant_after_rst", 32'(last_g), 32'd0);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      int mask;
      mask = $urandom_range(1, 3);
      for (int r = 0; r < 2; r++) begin
        if (mask[r]) begin
          logic [31:0] a, b;
          logic [3:0]  s;
          s = 4'($urandom_range(0, 15));
          a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
          b = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
          set_req(r, a, b, s);
        end
      end
      issue($urandom_range(0, 2), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
